// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin sequencer sharing one floating-point adder
//
// Purpose:
//   Grants one of NUM_REQ requesters at a time (round-robin from a rotating
//   pointer), registers the winner's operands onto the adder, raises the
//   adder enable and waits for adder_done. The result goes back to the owner
//   as a one-cycle resp_valid pulse. A watchdog ends the operation with
//   resp_error=1 if the adder never answers. Once an op has finished, no new
//   grant is issued until the adder's done has dropped.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   req_valid[N]          per-requester request
//   req_dataa/datab[32N]  operands, slice i = [32i+31:32i]
//   req_ready[N]          combinational one-hot accept
//   resp_valid[N]         one-hot completion pulse to the owner
//   resp_result[32]       result of the last completed op (0 on timeout)
//   resp_error            1 = watchdog timeout, valid with resp_valid
//   busy                  state != IDLE
//   adder_dataa/datab[32] registered operands to the adder
//   adder_enable          registered enable to the adder
//   adder_result[32]      adder result
//   adder_done            adder done (held while enable is held)

module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_dataa,
    input  logic [32*NUM_REQ-1:0]  req_datab,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_result,
    output logic                   resp_error,
    output logic                   busy,
    output logic [31:0]            adder_dataa,
    output logic [31:0]            adder_datab,
    output logic                   adder_enable,
    input  logic [31:0]            adder_result,
    input  logic                   adder_done
);

    localparam int         PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [7:0]         r_cnt;

    logic [PW-1:0]      w_win_hi;
    logic [PW-1:0]      w_win_lo;
    logic [PW-1:0]      w_winner;
    logic               w_found_hi;
    logic               w_found_lo;
    logic               w_any;
    logic               w_accept;
    logic               w_timeout;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic [NUM_REQ-1:0] w_win_onehot;
    logic [NUM_REQ-1:0] w_owner_onehot;

    // Round-robin search done as two linear scans: the lowest requester at or
    // above the pointer wins; if there is none, the lowest requester overall
    // wins (the wrap-around case).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_win_hi   = '0;
        w_win_lo   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !w_found_lo) begin
                w_found_lo = 1'b1;
                w_win_lo   = PW'(i);
            end
            if (req_valid[i] && !w_found_hi && (i >= int'(r_ptr))) begin
                w_found_hi = 1'b1;
                w_win_hi   = PW'(i);
            end
        end
    end

    assign w_any    = |req_valid;
    assign w_winner = w_found_hi ? w_win_hi : w_win_lo;

    // A grant needs the adder's done to be low as well, so a done still held
    // from an abandoned or just-finished op can never complete a new one.
    // reset_n is included so req_ready reads 0 while reset is held.
    assign w_accept  = reset_n && (r_state == S_IDLE) && !adder_done && w_any;
    assign w_timeout = (r_cnt == LAST_CNT);

    // Winner operand mux and one-hot decodes of the winner and the owner.
    always_comb begin
        w_win_onehot   = '0;
        w_owner_onehot = '0;
        w_sel_a        = '0;
        w_sel_b        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == PW'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_sel_a         = req_dataa[32*i +: 32];
                w_sel_b         = req_datab[32*i +: 32];
            end
            if (r_owner == PW'(i)) begin
                w_owner_onehot[i] = 1'b1;
            end
        end
    end

    assign req_ready = w_accept ? w_win_onehot : '0;
    assign busy      = (r_state != S_IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (adder_done || w_timeout) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!adder_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            adder_dataa  <= '0;
            adder_datab  <= '0;
            adder_enable <= 1'b0;
            resp_valid   <= '0;
            resp_result  <= '0;
            resp_error   <= 1'b0;
        end else begin
            resp_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        adder_dataa  <= w_sel_a;
                        adder_datab  <= w_sel_b;
                        adder_enable <= 1'b1;
                        r_owner      <= w_winner;
                        r_cnt        <= '0;
                        r_ptr        <= (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + PW'(1);
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 8'd1;
                    // done is checked first so a result arriving on the
                    // timeout cycle still completes without error.
                    if (adder_done) begin
                        resp_result  <= adder_result;
                        resp_error   <= 1'b0;
                        resp_valid   <= w_owner_onehot;
                        adder_enable <= 1'b0;
                    end else if (w_timeout) begin
                        resp_result  <= '0;
                        resp_error   <= 1'b1;
                        resp_valid   <= w_owner_onehot;
                        adder_enable <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
